// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: FSM encoding and
// timer sizing helper.
package pulse_stretcher_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ON   = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    // Width needed to hold max(high, gap) - 1, never less than one bit.
    function automatic int tmr_w(input int high, input int gap);
        int m;
        int w;
        m = (high > gap) ? high : gap;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pulse_stretcher_timer.sv
// Loadable down-counter that parks at zero; done flags the terminal
// count of the current ON or GAP phase.
module stretch_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into fixed-length high pulses, queueing
// events that arrive mid-stretch and replaying them with a low gap.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HIGH_CYCLES = 5_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int PEND_W      = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              pulse_in,
    output logic              pulse_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int TW = tmr_w(HIGH_CYCLES, GAP_CYCLES);

    localparam logic [TW-1:0] HI_LD  = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES - 1);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state_q;
    state_t            state_d;
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              out_q;
    logic              out_d;
    logic              busy_q;

    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_done;

    logic              pend_full;
    logic              gap_exit;
    logic              replay;

    stretch_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .nrst     (nrst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign pend_full = (pend_q == PEND_MAX);
    assign gap_exit  = (state_q == ST_GAP) && tmr_done;

    // An event on the GAP-exit edge counts toward the replay decision.
    assign replay = pulse_in || (pend_q != '0);

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        out_d    = out_q;
        tmr_load = 1'b0;
        tmr_val  = HI_LD;

        case (state_q)
            ST_IDLE: begin
                if (pulse_in) begin
                    state_d  = ST_ON;
                    tmr_load = 1'b1;
                    tmr_val  = HI_LD;
                    out_d    = 1'b1;
                end
            end

            ST_ON: begin
                if (pulse_in) begin
                    if (pend_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_d = pend_q + PEND_W'(1);
                    end
                end
                if (tmr_done) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LD;
                    out_d    = 1'b0;
                end
            end

            ST_GAP: begin
                if (gap_exit) begin
                    if (replay) begin
                        state_d  = ST_ON;
                        tmr_load = 1'b1;
                        tmr_val  = HI_LD;
                        out_d    = 1'b1;
                        if (!pulse_in) begin
                            pend_d = pend_q - PEND_W'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (pulse_in) begin
                    if (pend_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_d = pend_q + PEND_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                pend_d  = '0;
                out_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    assign pulse_out = out_q;
    assign busy      = busy_q;
    assign pending   = pend_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench: timeline-based reference model plus directed
// scenarios and randomized event traffic.
module tb_pulse_stretcher;

    localparam int H    = 4;
    localparam int G    = 3;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          pulse_in = 1'b0;
    logic          pulse_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    int n_chk  = 0;
    int n_pass = 0;

    pulse_stretcher #(
        .HIGH_CYCLES (H),
        .GAP_CYCLES  (G),
        .PEND_W      (PW)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .pulse_in  (pulse_in),
        .pulse_out (pulse_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk = n_chk + 1;
        if (act == exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a blink is described by its start edge; outputs follow from
    // the age of the current blink relative to HIGH and HIGH+GAP.
    longint m_t;
    longint m_start;
    bit     m_act;
    int     m_pend;
    bit     m_ovf;

    always @(posedge clk or negedge nrst) begin : model
        longint t;
        longint d;
        longint st;
        int     pd;
        bit     act;
        bit     ov;
        if (!nrst) begin
            m_t     <= 0;
            m_start <= 0;
            m_act   <= 1'b0;
            m_pend  <= 0;
            m_ovf   <= 1'b0;
        end else begin
            t   = m_t + 1;
            st  = m_start;
            act = m_act;
            pd  = m_pend;
            ov  = m_ovf;
            d   = t - st;
            if (act && d < H + G) begin
                if (pulse_in) begin
                    if (pd == PMAX) ov = 1'b1;
                    else pd = pd + 1;
                end
            end else if (act && d == H + G) begin
                if (pd + int'(pulse_in) > 0) begin
                    st = t;
                    pd = pd + int'(pulse_in) - 1;
                end else begin
                    act = 1'b0;
                end
            end else if (pulse_in) begin
                act = 1'b1;
                st  = t;
            end
            m_t     <= t;
            m_start <= st;
            m_act   <= act;
            m_pend  <= pd;
            m_ovf   <= ov;
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin : compare
        longint age;
        if (chk_en) begin
            age = m_t - m_start;
            chk("pulse_out", int'(pulse_out), int'(m_act && age < H));
            chk("busy", int'(busy), int'(m_act && age < H + G));
            chk("pending", int'(pending), m_pend);
            chk("overflow", int'(overflow), int'(m_ovf));
        end
    end

    task automatic cyc(input bit p);
        pulse_in = p;
        @(posedge clk);
        #1;
    endtask

    task automatic run_count(input int n, output int rises,
                             output int highs, output int busys);
        bit prev;
        prev  = pulse_out;
        rises = 0;
        highs = 0;
        busys = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1'b0);
            if (pulse_out && !prev) rises++;
            if (pulse_out) highs++;
            if (busy) busys++;
            prev = pulse_out;
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            cyc(1'b0);
            k++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    int r;
    int hi;
    int bz;

    initial begin
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pulse_out", int'(pulse_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_overflow", int'(overflow), 0);
        nrst   = 1'b1;
        chk_en = 1'b1;
        cyc(1'b0);

        // single event: 4 high, 7 busy
        cyc(1'b1);
        chk("single_latency", int'(pulse_out), 1);
        run_count(12, r, hi, bz);
        chk("single_high", hi + 1, 4);
        chk("single_busy", bz + 1, 7);
        chk("single_rises", r, 0);

        // three back-to-back events
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        chk("three_pend", int'(pending), 2);
        run_count(30, r, hi, bz);
        chk("three_rises", r, 2);
        chk("three_high", hi, 9);
        wait_idle(50);

        // five events saturate pending and overflow
        repeat (5) cyc(1'b1);
        chk("sat_pend", int'(pending), 3);
        chk("sat_ovf", int'(overflow), 1);
        run_count(40, r, hi, bz);
        chk("sat_rises", r, 3);
        chk("sat_high", hi, 12);
        chk("sat_ovf_sticky", int'(overflow), 1);
        chk("sat_idle", int'(busy), 0);
        nrst = 1'b0;
        cyc(1'b0);
        nrst = 1'b1;
        cyc(1'b0);

        // event on GAP-exit edge with pending=1
        cyc(1'b1);
        cyc(1'b1);
        repeat (5) cyc(1'b0);
        chk("gx1_pre_out", int'(pulse_out), 0);
        cyc(1'b1);
        chk("gx1_out", int'(pulse_out), 1);
        chk("gx1_pend", int'(pending), 1);
        chk("gx1_ovf", int'(overflow), 0);
        run_count(30, r, hi, bz);
        chk("gx1_rises", r, 1);
        wait_idle(50);

        // event on GAP-exit edge with pending=0: no idle cycle
        cyc(1'b1);
        repeat (6) cyc(1'b0);
        chk("gx0_pre_busy", int'(busy), 1);
        cyc(1'b1);
        chk("gx0_out", int'(pulse_out), 1);
        chk("gx0_busy", int'(busy), 1);
        chk("gx0_pend", int'(pending), 0);
        wait_idle(50);

        // asynchronous reset mid-ON with pending=2
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_pulse_out", int'(pulse_out), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_pending", int'(pending), 0);
        chk("arst_overflow", int'(overflow), 0);
        @(posedge clk);
        #1;
        cyc(1'b0);
        nrst = 1'b1;
        cyc(1'b1);
        chk("arst_blink_start", int'(pulse_out), 1);
        run_count(12, r, hi, bz);
        chk("arst_blink_high", hi + 1, 4);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int dens;
            dens = (i / 200) % 4;
            dens = (dens == 0) ? 0 : (dens == 1) ? 2 : (dens == 2) ? 6 : 15;
            if (i == 1500) begin
                nrst = 1'b0;
                cyc(1'b0);
                nrst = 1'b1;
            end
            cyc($urandom_range(0, dens) == 0);
        end
        wait_idle(200);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Inverse of the switch debouncer: consumes single-cycle event pulses (one_shot style) and drives a clean, human-visible output level of fixed duration per event, e.g. an LED or external strobe on the MIPS_UART board.
- Events arriving while a stretch is in progress are queued in a saturating pending counter and replayed as separate pulses, with a guaranteed low gap between them.
- Sits between the debounce/UART event sources and board-level outputs.

Parameters:
- HIGH_CYCLES, 5_000_000, clock cycles the output is held high per event (100 ms at 50 MHz); must be >= 1.
- GAP_CYCLES, 2_500_000, minimum clock cycles the output is held low between consecutive stretched pulses; must be >= 1.
- PEND_W, 4, width of the pending-event counter; it saturates at 2^PEND_W-1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- nrst  input  1  asynchronous, active-low reset.
- pulse_in  input  1  event strobe, sampled every rising edge; each high cycle is one event.
- pulse_out  output  1  registered stretched output.
- busy  output  1  high whenever state != IDLE (registered state decode).
- pending  output  PEND_W  number of queued, not-yet-started events.
- overflow  output  1  sticky flag; set when an event arrives while pending is saturated; cleared only by reset.

Behaviour:
- Reset (nrst low, asynchronous): state=IDLE, timer=0, pending=0, overflow=0, pulse_out=0, busy=0. Outputs drop immediately without waiting for a clock edge, including in mid-ON or mid-GAP.
- FSM states: IDLE, ON, GAP.
- IDLE: pending is always 0 here. If pulse_in=1 on an edge, go to ON, load timer with HIGH_CYCLES-1, and set pulse_out=1 from that edge. Latency is 1 cycle. This event is consumed directly and is not added to pending.
- ON: pulse_out=1; timer decrements each edge. On the edge where timer==0, go to GAP, load timer with GAP_CYCLES-1, and set pulse_out=0.
- ON therefore lasts exactly HIGH_CYCLES cycles.
- GAP: pulse_out=0; timer decrements each edge. On the edge where timer==0:
  - if the effective pending count > 0, go to ON, reload HIGH_CYCLES-1, pulse_out=1, and decrement pending;
  - otherwise go to IDLE.
- GAP therefore lasts exactly GAP_CYCLES cycles. Blink start-to-start period is HIGH_CYCLES+GAP_CYCLES.
- pulse_in=1 in ON or GAP: pending increments by 1, saturating at 2^PEND_W-1. If pending is already saturated, set overflow=1 and drop the event.
- Simultaneous increment and decrement (pulse_in=1 on the GAP-exit edge with pending>0): pending is unchanged and the FSM goes to ON.
- pulse_in=1 on the GAP-exit edge with pending==0: that event counts as effective pending. Go to ON, pending stays 0, and no idle cycle is inserted.
- pulse_in=1 on the ON-exit edge: increments pending normally.
- pulse_in held high for N cycles counts as N events. The block performs no edge detection.
- Timer width is $clog2(max(HIGH_CYCLES,GAP_CYCLES)), minimum 1. The timer never wraps; it is only loaded or decremented from a non-zero value.
- All outputs are registered. There are no combinational paths from pulse_in to any output.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, ON=2'd1, GAP=2'd2) and a clog2 helper/localparam for timer width.
- One sub-module: stretch_timer. It is a loadable down-counter with inputs load and load_val, and output done (count==0). It runs on clk with asynchronous nrst.
- The FSM and pending counter live in pulse_stretcher.

Test Plan (HIGH_CYCLES=4, GAP_CYCLES=3, PEND_W=2):
- Single pulse_in at edge k -> pulse_out=1 for edges k..k+3 (4 cycles), then 0; busy=1 for 7 cycles; pending stays 0; back to IDLE.
- pulse_in on 3 consecutive edges from IDLE -> pending 0,1,2. pulse_out pattern is 4 high / 3 low / 4 high / 3 low / 4 high. pending drops 2->1->0 at each GAP exit.
- 5 pulses back-to-back from IDLE -> 1 consumed, pending saturates at 3, overflow=1 sticky. Exactly 4 high pulses are produced, then IDLE with overflow still 1.
- pending=1 and pulse_in=1 exactly on the GAP-exit edge -> ON starts, pending remains 1, overflow=0. A further blink follows.
- nrst asserted mid-ON with pending=2, between clock edges -> pulse_out, busy, pending, overflow all 0 immediately. After release, one pulse_in gives a normal 4-cycle blink.
- pulse_in on the final GAP edge with pending=0 -> pulse_out rises on that edge with no IDLE cycle, and pending stays 0.
